btn_conditioner: RTL and testbench

- Conditions the five raw front-panel push-buttons (P, R, L, U, D) before they reach the user-control state machine of the clock/timer design.
- Per button: synchronises to `clk`, debounces, and emits a single-cycle press pulse.
- Optionally adds hold-to-repeat on U and D, so holding a button steps BCD fields repeatedly.
- Outputs drive the control FSM's BTNP/BTNR/BTNL/BTNU/BTND inputs directly.

---
 rtl/btn_pkg.sv | 28 ++
 rtl/btn_debounce_ch.sv | 150 +++++++++++++++
 rtl/btn_conditioner.sv | 66 ++++++
 tb/tb_btn_conditioner.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
// Shared constants and types for the front-panel button conditioner.
//   - Button index constants into the 5-bit button vectors {P,R,L,U,D}.
//   - Auto-repeat state encoding used by the U/D channels.
//   - max_int() helper for sizing the repeat counter.
// -----------------------------------------------------------------------------
package btn_pkg;

  localparam int NUM_BTNS = 5;

  localparam int BTN_P = 4;
  localparam int BTN_R = 3;
  localparam int BTN_L = 2;
  localparam int BTN_U = 1;
  localparam int BTN_D = 0;

  typedef enum logic [1:0] {
    RPT_IDLE = 2'd0,
    RPT_WAIT = 2'd1,
    RPT_RUN  = 2'd2
  } rpt_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// -----------------------------------------------------------------------------
// btn_debounce_ch
// One button channel: two-flop synchroniser, debounce counter, registered
// single-cycle press pulse and, when HAS_REPEAT is set, a hold-to-repeat
// state machine that adds repeat pulses onto the same pulse output.
//
// Ports:
//   clk         in  system clock
//   reset       in  asynchronous, active-high reset
//   btn_raw_i   in  raw asynchronous button, active-high
//   level_o     out debounced button level
//   pulse_o     out one-cycle press pulse (plus repeat pulses if HAS_REPEAT)
// -----------------------------------------------------------------------------
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES     = 500000,
  parameter int REPEAT_DELAY_CYCLES = 50000000,
  parameter int REPEAT_RATE_CYCLES  = 10000000,
  parameter bit HAS_REPEAT          = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw_i,
  output logic level_o,
  output logic pulse_o
);

  localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            level_q, level_d;
  logic            rise;
  logic            rpt_d;
  logic            pulse_q;

  // NOTE: every sequential block uses non-blocking (<=) assignments so all
  // flops update together from the values present before the clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw_i;
      sync2_q <= sync1_q;
    end
  end

  // The counter only runs while the synchronised input disagrees with the
  // accepted level; it is cleared on agreement and on accept, so it can never
  // exceed DB_LAST.
  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    db_cnt_d = db_cnt_q;
    level_d  = level_q;
    if (sync2_q == level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      level_d  = sync2_q;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  // Press is the edge at which the accepted level goes 0 -> 1.
  assign rise = ~level_q & level_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_cnt_q <= '0;
      level_q  <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      db_cnt_q <= db_cnt_d;
      level_q  <= level_d;
      pulse_q  <= rise | rpt_d;
    end
  end

  assign level_o = level_q;
  assign pulse_o = pulse_q;

  if (HAS_REPEAT) begin : g_rpt
    localparam int              RPT_MAX    = max_int(REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES);
    localparam int              RPT_W      = $clog2(RPT_MAX);
    localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE_CYCLES - 1);

    rpt_state_e       state_q, state_d;
    logic [RPT_W-1:0] cnt_q, cnt_d;
    logic             fall;

    assign fall = level_q & ~level_d;

    // The FSM moves on the same edge that launches the press pulse, so in the
    // press-pulse cycle the counter already reads 0. A pulse decided here is
    // registered, hence it appears when the counter has just reached *_LAST.
    always_comb begin
      state_d = state_q;
      cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;  // saturate, never wrap
      rpt_d   = 1'b0;
      case (state_q)
        RPT_IDLE: begin
          cnt_d = '0;
          if (rise) state_d = RPT_WAIT;
        end
        RPT_WAIT: begin
          if (cnt_q == DELAY_LAST) begin
            rpt_d   = 1'b1;
            state_d = RPT_RUN;
            cnt_d   = '0;
          end
        end
        RPT_RUN: begin
          if (cnt_q == RATE_LAST) begin
            rpt_d = 1'b1;
            cnt_d = '0;
          end
        end
        default: begin
          state_d = RPT_IDLE;
          cnt_d   = '0;
        end
      endcase
      // Release wins over everything, including a repeat due this cycle.
      if (fall) begin
        state_d = RPT_IDLE;
        cnt_d   = '0;
        rpt_d   = 1'b0;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= RPT_IDLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end
  end else begin : g_no_rpt
    assign rpt_d = 1'b0;
  end

endmodule

// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
// Conditions the five raw front-panel buttons {P,R,L,U,D} for the control FSM:
// synchronise, debounce and emit one-cycle press pulses per button.
//
// Build option:
//   BTN_AUTOREPEAT_EN  when defined, U and D also emit hold-to-repeat pulses;
//                      when undefined, all five channels are press-only.
//
// Ports:
//   clk        in  system clock
//   reset      in  asynchronous, active-high reset
//   btn_raw    in  [4:0] raw buttons {P,R,L,U,D}, active-high
//   btn_level  out [4:0] debounced levels, same order
//   btnp/btnr/btnl/btnu/btnd out one-cycle pulses per button
// -----------------------------------------------------------------------------
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES     = 500000,
  parameter int REPEAT_DELAY_CYCLES = 50000000,
  parameter int REPEAT_RATE_CYCLES  = 10000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_BTNS-1:0] btn_raw,
  output logic [NUM_BTNS-1:0] btn_level,
  output logic                btnp,
  output logic                btnr,
  output logic                btnl,
  output logic                btnu,
  output logic                btnd
);

`ifdef BTN_AUTOREPEAT_EN
  localparam bit UD_REPEAT = 1'b1;
`else
  localparam bit UD_REPEAT = 1'b0;
`endif

  logic [NUM_BTNS-1:0] pulse;

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
    localparam bit CH_REPEAT = UD_REPEAT && ((i == BTN_U) || (i == BTN_D));

    btn_debounce_ch #(
      .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
      .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
      .REPEAT_RATE_CYCLES  (REPEAT_RATE_CYCLES),
      .HAS_REPEAT          (CH_REPEAT)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .btn_raw_i (btn_raw[i]),
      .level_o   (btn_level[i]),
      .pulse_o   (pulse[i])
    );
  end

  assign btnp = pulse[BTN_P];
  assign btnr = pulse[BTN_R];
  assign btnl = pulse[BTN_L];
  assign btnu = pulse[BTN_U];
  assign btnd = pulse[BTN_D];

endmodule

// File: tb/tb_btn_conditioner.sv
// -----------------------------------------------------------------------------
// tb_btn_conditioner
// Directed bench for btn_conditioner with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY_CYCLES=20, REPEAT_RATE_CYCLES=8. Honours BTN_AUTOREPEAT_EN for
// the expected U/D repeat pulses. Cycle k of a scenario starts 1 time unit
// after the k-th rising edge following the stimulus; outputs are sampled on
// the falling edge inside that cycle.
// -----------------------------------------------------------------------------
module tb_btn_conditioner;
  import btn_pkg::*;

`ifdef BTN_AUTOREPEAT_EN
  localparam bit RPT = 1'b1;
`else
  localparam bit RPT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] btn_raw;
  logic [4:0] btn_level;
  logic       btnp, btnr, btnl, btnu, btnd;
  logic [9:0] obs;
  logic [9:0] exp_v;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  btn_conditioner #(
    .DEBOUNCE_CYCLES     (4),
    .REPEAT_DELAY_CYCLES (20),
    .REPEAT_RATE_CYCLES  (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_raw   (btn_raw),
    .btn_level (btn_level),
    .btnp      (btnp),
    .btnr      (btnr),
    .btnl      (btnl),
    .btnu      (btnu),
    .btnd      (btnd)
  );

  // Observation vector: {btn_level[4:0], btnp, btnr, btnl, btnu, btnd}.
  assign obs = {btn_level, btnp, btnr, btnl, btnu, btnd};

  task automatic check(input string tag, input logic [9:0] got, input logic [9:0] want);
    checks++;
    assert (got === want)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, got, want);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset   = 1'b1;
    btn_raw = 5'b0;

    // 1. Reset dominates even with every raw button high.
    next_cycle();
    btn_raw = 5'b11111;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("reset_hold c%0d", k), obs, 10'b0);
      next_cycle();
    end
    btn_raw = 5'b0;
    next_cycle();
    reset = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      check($sformatf("idle c%0d", k), obs, 10'b0);
      next_cycle();
    end

    // 2. P press at cycle 0, release at cycle 30.
    for (int k = 0; k <= 40; k++) begin
      if (k == 0)  btn_raw[BTN_P] = 1'b1;
      if (k == 30) btn_raw[BTN_P] = 1'b0;
      exp_v = '0;
      exp_v[5+BTN_P] = (k >= 6) && (k < 36);
      exp_v[BTN_P]   = (k == 6);
      @(negedge clk);
      check($sformatf("p_press c%0d", k), obs, exp_v);
      next_cycle();
    end

    // 3. R glitch high for 3 cycles: filtered out.
    for (int k = 0; k < 15; k++) begin
      if (k == 0) btn_raw[BTN_R] = 1'b1;
      if (k == 3) btn_raw[BTN_R] = 1'b0;
      @(negedge clk);
      check($sformatf("r_glitch c%0d", k), obs, 10'b0);
      next_cycle();
    end

    // 4. U held for 60 cycles: press at 6, repeats 26,34,42,50,58 if enabled.
    for (int k = 0; k <= 80; k++) begin
      if (k == 0)  btn_raw[BTN_U] = 1'b1;
      if (k == 60) btn_raw[BTN_U] = 1'b0;
      exp_v = '0;
      exp_v[5+BTN_U] = (k >= 6) && (k < 66);
      exp_v[BTN_U]   = (k == 6) ||
                       (RPT && (k == 26 || k == 34 || k == 42 || k == 50 || k == 58));
      @(negedge clk);
      check($sformatf("u_hold c%0d", k), obs, exp_v);
      next_cycle();
    end

    // 5. D held; reset at cycle 15 for 2 cycles; new press pulse at 23.
    for (int k = 0; k <= 45; k++) begin
      if (k == 0)  btn_raw[BTN_D] = 1'b1;
      if (k == 15) reset = 1'b1;
      if (k == 17) reset = 1'b0;
      if (k == 31) btn_raw[BTN_D] = 1'b0;
      exp_v = '0;
      exp_v[5+BTN_D] = ((k >= 6) && (k < 15)) || ((k >= 23) && (k < 37));
      exp_v[BTN_D]   = (k == 6) || (k == 23);
      @(negedge clk);
      check($sformatf("d_reset c%0d", k), obs, exp_v);
      next_cycle();
    end

    // 6. U and L together: both pulse at cycle 6.
    for (int k = 0; k <= 20; k++) begin
      if (k == 0) begin
        btn_raw[BTN_U] = 1'b1;
        btn_raw[BTN_L] = 1'b1;
      end
      if (k == 11) begin
        btn_raw[BTN_U] = 1'b0;
        btn_raw[BTN_L] = 1'b0;
      end
      exp_v = '0;
      exp_v[5+BTN_U] = (k >= 6) && (k < 17);
      exp_v[5+BTN_L] = (k >= 6) && (k < 17);
      exp_v[BTN_U]   = (k == 6);
      exp_v[BTN_L]   = (k == 6);
      @(negedge clk);
      check($sformatf("u_l_simul c%0d", k), obs, exp_v);
      next_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
